button_param_ctrl: RTL and testbench

//  Operator-input controller behind the debounced push-buttons. Turns UP/DOWN/SEL presses into steps
//  on a bank of N_PARAM runtime setpoints for the converter control loop, with saturation and auto-repeat.

---
 rtl/hybrid_ctrl_pkg.sv | 40 ++++
 rtl/btn_edge_detect.sv | 31 +++
 rtl/button_param_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_button_param_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_ctrl_pkg.sv
// Shared types and helpers for the operator push-button controller.
//   btn_state_t : button FSM states (IDLE, HOLD, REPEAT, LOCK)
//   sat_step()  : one saturating up/down step on an unsigned setpoint
package hybrid_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } btn_state_t;

    // One bit of headroom keeps v+step from wrapping, and the down step is
    // compared before subtracting so it can never go below lo.
    function automatic logic [31:0] sat_step(
        input logic [31:0] v,
        input logic        up,
        input logic [31:0] step,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [32:0] t;
        if (up) begin
            t = {1'b0, v} + {1'b0, step};
            if (t > {1'b0, hi}) begin
                t = {1'b0, hi};
            end else begin
                t = t;
            end
        end else begin
            if ({1'b0, v} < ({1'b0, lo} + {1'b0, step})) begin
                t = {1'b0, lo};
            end else begin
                t = {1'b0, v} - {1'b0, step};
            end
        end
        return t[31:0];
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Press-edge detector for one debounced, active-low, idle-high button.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset (history forced to released)
//   btn     : debounced button, 0 = pressed
//   press   : 1 in the cycle where btn is first sampled low after being high
//   pressed : level, 1 while the button is held
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic pressed
);

    logic hist_r;

    // History of the previous sample; reset to "released" so a button held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= 1'b1;
        end else begin
            hist_r <= btn;
        end
    end

    assign press   = hist_r & ~btn;
    assign pressed = ~btn;

endmodule

// File: rtl/button_param_ctrl.sv
// Operator-input controller: UP/DOWN step the selected setpoint with
// saturation, SEL cycles which setpoint is edited.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat; when undefined,
// exactly one step per press and o_hold is tied low).
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_btn_up/down/sel         : debounced buttons, 0 = pressed
//   o_param [N_PARAM*W]       : setpoint bank, param k at [k*W +: W]
//   o_sel                     : index of the setpoint being edited
//   o_update                  : 1-cycle pulse when a setpoint really changed
//   o_hold                    : high while in HOLD or REPEAT
module button_param_ctrl
    import hybrid_ctrl_pkg::*;
#(
    parameter int N_PARAM     = 4,
    parameter int W           = 16,
    parameter int STEP        = 1,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 1000,
    parameter int RESET_VAL   = 500,
    parameter int HOLD_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 5_000_000,
    localparam int SEL_W      = $clog2(N_PARAM)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_btn_up,
    input  logic                 i_btn_down,
    input  logic                 i_btn_sel,
    output logic [N_PARAM*W-1:0] o_param,
    output logic [SEL_W-1:0]     o_sel,
    output logic                 o_update,
    output logic                 o_hold
);

    logic up_edge_s, up_lvl_s, dn_edge_s, dn_lvl_s, sel_edge_s, sel_lvl_s;

    btn_edge_detect u_up  (.clk(i_clk), .reset(i_reset), .btn(i_btn_up),
                           .press(up_edge_s),  .pressed(up_lvl_s));
    btn_edge_detect u_dn  (.clk(i_clk), .reset(i_reset), .btn(i_btn_down),
                           .press(dn_edge_s),  .pressed(dn_lvl_s));
    btn_edge_detect u_sel (.clk(i_clk), .reset(i_reset), .btn(i_btn_sel),
                           .press(sel_edge_s), .pressed(sel_lvl_s));

    btn_state_t       state_r, state_next_s;
    logic [W-1:0]     param_r [N_PARAM];
    logic [SEL_W-1:0] sel_r;
    logic             update_r;
    logic             do_step_s, step_up_s, sel_inc_s;
    logic [W-1:0]     cur_s, stepped_s;

`ifdef BTN_AUTOREPEAT_EN
    localparam int CNT_W = $clog2((HOLD_TIME > REPEAT_TIME) ? HOLD_TIME : REPEAT_TIME) + 1;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             dir_up_r, dir_up_next_s;
    logic             hold_r;
    logic             act_lvl_s, oth_lvl_s;

    // Level of the button that started this hold, and of the opposing one.
    assign act_lvl_s = dir_up_r ? up_lvl_s : dn_lvl_s;
    assign oth_lvl_s = dir_up_r ? dn_lvl_s : up_lvl_s;
`endif

    // Next-state and step/select decisions.
    always_comb begin
        state_next_s = state_r;
        do_step_s    = 1'b0;
        step_up_s    = 1'b0;
        sel_inc_s    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        cnt_next_s    = cnt_r;
        dir_up_next_s = dir_up_r;
`endif
        case (state_r)
            IDLE: begin
                if (up_lvl_s && dn_lvl_s) begin
                    state_next_s = LOCK;
                end else if (up_edge_s || dn_edge_s) begin
                    do_step_s = 1'b1;
                    step_up_s = up_edge_s;
`ifdef BTN_AUTOREPEAT_EN
                    dir_up_next_s = up_edge_s;
                    cnt_next_s    = '0;
                    state_next_s  = HOLD;
`else
                    state_next_s  = LOCK;
`endif
                end else if (sel_edge_s && !up_lvl_s && !dn_lvl_s) begin
                    sel_inc_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            HOLD, REPEAT: begin
                step_up_s = dir_up_r;
                if (!act_lvl_s) begin
                    state_next_s = IDLE;
                end else if (oth_lvl_s) begin
                    state_next_s = LOCK;
                end else if ((state_r == HOLD   && cnt_r == CNT_W'(HOLD_TIME - 1)) ||
                             (state_r == REPEAT && cnt_r == CNT_W'(REPEAT_TIME - 1))) begin
                    do_step_s    = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = REPEAT;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
`endif
            LOCK: begin
                if (!up_lvl_s && !dn_lvl_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Saturating step of the currently selected setpoint.
    always_comb begin
        cur_s     = param_r[sel_r];
        stepped_s = W'(sat_step(32'(cur_s), step_up_s, 32'(STEP),
                                32'(MIN_VAL), 32'(MAX_VAL)));
    end

    // State, setpoint bank, selection and registered pulse outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= IDLE;
            sel_r    <= '0;
            update_r <= 1'b0;
            for (int k = 0; k < N_PARAM; k++) begin
                param_r[k] <= W'(RESET_VAL);
            end
`ifdef BTN_AUTOREPEAT_EN
            cnt_r    <= '0;
            dir_up_r <= 1'b1;
            hold_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            if (do_step_s) begin
                param_r[sel_r] <= stepped_s;
                update_r       <= (stepped_s != cur_s);
            end else begin
                update_r <= 1'b0;
            end
            if (sel_inc_s) begin
                sel_r <= (sel_r == SEL_W'(N_PARAM - 1)) ? '0 : sel_r + SEL_W'(1);
            end else begin
                sel_r <= sel_r;
            end
`ifdef BTN_AUTOREPEAT_EN
            cnt_r    <= cnt_next_s;
            dir_up_r <= dir_up_next_s;
            hold_r   <= (state_next_s == HOLD) || (state_next_s == REPEAT);
`endif
        end
    end

    // Flatten the setpoint bank onto the output bus.
    always_comb begin
        o_param = '0;
        for (int k = 0; k < N_PARAM; k++) begin
            o_param[k*W +: W] = param_r[k];
        end
    end

    assign o_sel    = sel_r;
    assign o_update = update_r;
`ifdef BTN_AUTOREPEAT_EN
    assign o_hold   = hold_r;
`else
    assign o_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_button_param_ctrl.sv
module tb_button_param_ctrl;

    localparam int NP   = 4;
    localparam int WD   = 8;
    localparam int MINV = 0;
    localparam int MAXV = 10;
    localparam int RSTV = 5;
    localparam int HT   = 8;
    localparam int RT   = 4;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_btn_up = 1'b1;
    logic            i_btn_down = 1'b1;
    logic            i_btn_sel = 1'b1;
    logic [NP*WD-1:0] o_param;
    logic [1:0]      o_sel;
    logic            o_update;
    logic            o_hold;

    button_param_ctrl #(
        .N_PARAM(NP), .W(WD), .STEP(1), .MIN_VAL(MINV), .MAX_VAL(MAXV),
        .RESET_VAL(RSTV), .HOLD_TIME(HT), .REPEAT_TIME(RT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_btn_up(i_btn_up),
        .i_btn_down(i_btn_down), .i_btn_sel(i_btn_sel),
        .o_param(o_param), .o_sel(o_sel), .o_update(o_update), .o_hold(o_hold)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int upd_seen = 0;

    // Reference model: behaviour expressed as "how long has the active
    // button been held" rather than as states and counters.
    int m_param [NP];
    int m_sel;
    bit m_locked;
    int m_active;          // +1 UP held, -1 DOWN held, 0 none
    int m_age;             // cycles since the press edge of the active button
    bit m_prev_up, m_prev_dn, m_prev_sel;
    bit m_upd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_step(input bit up);
        int v;
        v = m_param[m_sel];
        if (up) v = (v + 1 > MAXV) ? MAXV : v + 1;
        else    v = (v - 1 < MINV) ? MINV : v - 1;
        m_upd = (v != m_param[m_sel]);
        m_param[m_sel] = v;
    endtask

    task automatic model_edge(input bit up_n, input bit dn_n, input bit sel_n, input bit rst);
        bit up_p, dn_p, sel_p, up_e, dn_e, sel_e, act, oth;
        up_p = !up_n; dn_p = !dn_n; sel_p = !sel_n;
        up_e = up_p && !m_prev_up; dn_e = dn_p && !m_prev_dn; sel_e = sel_p && !m_prev_sel;
        m_upd = 1'b0;
        if (rst) begin
            for (int k = 0; k < NP; k++) m_param[k] = RSTV;
            m_sel = 0; m_locked = 1'b0; m_active = 0; m_age = 0;
            m_prev_up = 1'b0; m_prev_dn = 1'b0; m_prev_sel = 1'b0;
        end else begin
            if (m_locked) begin
                if (!up_p && !dn_p) m_locked = 1'b0;
            end else if (m_active != 0) begin
                act = (m_active > 0) ? up_p : dn_p;
                oth = (m_active > 0) ? dn_p : up_p;
                if (!act) m_active = 0;
                else if (oth) begin m_active = 0; m_locked = 1'b1; end
                else begin
                    m_age++;
                    if (m_age == HT || (m_age > HT && (m_age - HT) % RT == 0))
                        m_step(m_active > 0);
                end
            end else begin
                if (up_p && dn_p) m_locked = 1'b1;
                else if (up_e || dn_e) begin
                    m_step(up_e);
`ifdef BTN_AUTOREPEAT_EN
                    m_active = up_e ? 1 : -1;
                    m_age = 0;
`else
                    m_locked = 1'b1;
`endif
                end else if (sel_e && !up_p && !dn_p) m_sel = (m_sel + 1) % NP;
            end
            m_prev_up = up_p; m_prev_dn = dn_p; m_prev_sel = sel_p;
        end
    endtask

    task automatic check_outputs();
        logic [NP*WD-1:0] exp_p;
        for (int k = 0; k < NP; k++) exp_p[k*WD +: WD] = WD'(m_param[k]);
        chk("param", 64'(o_param), 64'(exp_p));
        chk("sel", 64'(o_sel), 64'(m_sel));
        chk("update", 64'(o_update), 64'(m_upd));
        chk("hold", 64'(o_hold), 64'(m_active != 0));
    endtask

    task automatic cyc(input bit up_n, input bit dn_n, input bit sel_n, input bit rst);
        i_btn_up = up_n; i_btn_down = dn_n; i_btn_sel = sel_n; i_reset = rst;
        @(posedge clk);
        model_edge(up_n, dn_n, sel_n, rst);
        #1;
        upd_seen += int'(o_update);
        check_outputs();
    endtask

    task automatic hold_pat(input bit up_n, input bit dn_n, input bit sel_n, input int n);
        for (int i = 0; i < n; i++) cyc(up_n, dn_n, sel_n, 1'b0);
    endtask

    task automatic tap(input bit up_n, input bit dn_n, input bit sel_n);
        hold_pat(up_n, dn_n, sel_n, 3);
        hold_pat(1'b1, 1'b1, 1'b1, 2);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        i_reset = 1'b0;
    endtask

    initial begin
        int sel_exp [5];
        logic [31:0] vec;
        int pat, len;
        sel_exp = '{1, 2, 3, 0, 1};

        // 1: reset state, single UP tap
        do_reset();
        chk("t1_reset_param", 64'(o_param), 64'(32'h05050505));
        chk("t1_reset_sel", 64'(o_sel), 64'd0);
        upd_seen = 0;
        tap(1'b0, 1'b1, 1'b1);
        chk("t1_param0", 64'(o_param[7:0]), 64'd6);
        chk("t1_upd_pulses", 64'(upd_seen), 64'd1);

        // 2: hold DOWN 20 cycles
        do_reset();
        hold_pat(1'b1, 1'b0, 1'b1, 20);
`ifdef BTN_AUTOREPEAT_EN
        chk("t2_param0", 64'(o_param[7:0]), 64'd1);
`else
        chk("t2_param0", 64'(o_param[7:0]), 64'd4);
`endif
        hold_pat(1'b1, 1'b1, 1'b1, 2);

        // 3: saturation at both bounds
        do_reset();
        for (int i = 0; i < 4; i++) tap(1'b0, 1'b1, 1'b1);
        upd_seen = 0;
        hold_pat(1'b0, 1'b1, 1'b1, 30);
        chk("t3_max", 64'(o_param[7:0]), 64'd10);
        chk("t3_max_upd", 64'(upd_seen), 64'd1);
        hold_pat(1'b1, 1'b1, 1'b1, 2);
        for (int i = 0; i < 12; i++) tap(1'b1, 1'b0, 1'b1);
        upd_seen = 0;
        tap(1'b1, 1'b0, 1'b1);
        chk("t3_min", 64'(o_param[7:0]), 64'd0);
        chk("t3_min_upd", 64'(upd_seen), 64'd0);

        // 4: SEL wraps, UP edits only the selected setpoint
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tap(1'b1, 1'b1, 1'b0);
            chk("t4_sel", 64'(o_sel), 64'(sel_exp[i]));
        end
        tap(1'b0, 1'b1, 1'b1);
        vec = 32'h05050605;
        chk("t4_param", 64'(o_param), 64'(vec));

        // 5: UP+DOWN together lock until both released
        do_reset();
        hold_pat(1'b0, 1'b0, 1'b1, 3);
        hold_pat(1'b1, 1'b0, 1'b1, 3);
        hold_pat(1'b0, 1'b0, 1'b1, 2);
        chk("t5_locked", 64'(o_param[7:0]), 64'd5);
        hold_pat(1'b1, 1'b1, 1'b1, 2);
        tap(1'b0, 1'b1, 1'b1);
        chk("t5_unlocked", 64'(o_param[7:0]), 64'd6);

        // 6: reset mid-hold, button still held afterwards
        do_reset();
        tap(1'b1, 1'b1, 1'b0);
        tap(1'b1, 1'b1, 1'b0);
        hold_pat(1'b0, 1'b1, 1'b1, 15);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6_rst_param", 64'(o_param), 64'(32'h05050505));
        chk("t6_rst_sel", 64'(o_sel), 64'd0);
        chk("t6_rst_hold", 64'(o_hold), 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_after", 64'(o_param[7:0]), 64'd6);
        hold_pat(1'b1, 1'b1, 1'b1, 2);

        // Randomized button activity against the model
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                cyc(1'b1, 1'b1, 1'b1, 1'b1);
            end else begin
                pat = int'($urandom_range(0, 9));
                len = int'($urandom_range(1, 20));
                case (pat)
                    0, 1, 2: hold_pat(1'b0, 1'b1, 1'b1, len);
                    3, 4, 5: hold_pat(1'b1, 1'b0, 1'b1, len);
                    6, 7:    hold_pat(1'b1, 1'b1, 1'b0, len);
                    8:       hold_pat(1'b0, 1'b0, 1'b1, len);
                    default: hold_pat(1'b0, 1'b1, 1'b0, len);
                endcase
                hold_pat(1'b1, 1'b1, 1'b1, int'($urandom_range(1, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
